// File: rtl/elevator_motion_controller_if.sv
// Bus between the memory manager (master) and the cabin motion controller (slave).
// Optional macro ELEVATOR_DOOR_HOLD_EN adds the DoorHold request line.
//
// Signalling: every line is a plain level with no valid/ready pair. The master
// holds NoStopRequest/UDRequest steady while Stop=1 until the cabin starts
// moving. OCRequest is edge-qualified in IDLE and level-sampled in EVAL.
// Delay is a one-cycle strobe on each floor arrival. All slave outputs
// are registered. fsm_state mirrors the controller state register for debug.
interface elevator_motion_controller_if;
    logic       NoStopRequest;
    logic       UDRequest;
    logic       OCRequest;
    logic [3:0] StopsUp;
    logic [3:0] StopsDw;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic       DoorHold;
`endif
    logic [1:0] CurrentFloor;
    logic       UDIn;
    logic       Delay;
    logic       Stop;
    logic       Moving;
    logic       DoorOpen;
    logic [2:0] fsm_state;

`ifdef ELEVATOR_DOOR_HOLD_EN
    modport master (
        output NoStopRequest, UDRequest, OCRequest, StopsUp, StopsDw, DoorHold,
        input  CurrentFloor, UDIn, Delay, Stop, Moving, DoorOpen, fsm_state
    );
    modport slave (
        input  NoStopRequest, UDRequest, OCRequest, StopsUp, StopsDw, DoorHold,
        output CurrentFloor, UDIn, Delay, Stop, Moving, DoorOpen, fsm_state
    );
`else
    modport master (
        output NoStopRequest, UDRequest, OCRequest, StopsUp, StopsDw,
        input  CurrentFloor, UDIn, Delay, Stop, Moving, DoorOpen, fsm_state
    );
    modport slave (
        input  NoStopRequest, UDRequest, OCRequest, StopsUp, StopsDw,
        output CurrentFloor, UDIn, Delay, Stop, Moving, DoorOpen, fsm_state
    );
`endif
endinterface

// File: rtl/elevator_motion_controller.sv
// Cabin motion and door sequencer for a 4-floor shaft.
// Travel time per floor and door dwell are modelled with one shared cycle counter.
// Optional macro ELEVATOR_DOOR_HOLD_EN: DoorHold keeps the door counter at 0
// while high, which extends the dwell.
module elevator_motion_controller #(
    parameter int TRAVEL_TICKS = 8,
    parameter int DOOR_TICKS   = 6
) (
    input logic clk,
    input logic reset,
    elevator_motion_controller_if.slave bus
);

    localparam int CNT_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOVE   = 3'd1,
        ARRIVE = 3'd2,
        EVAL   = 3'd3,
        DOOR   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          oc_q;
    logic [1:0]    floor;
    logic          ud;

    logic          oc_rise;
    logic          move_legal;
    logic          stop_beyond;
    logic          door_hold;
    logic [3:0]    stops;

    // A door request in IDLE counts only on its rising edge, so a request left
    // high from an earlier arrival cannot reopen the door.
    assign oc_rise    = bus.OCRequest & ~oc_q;
    assign move_legal = bus.UDRequest ? (floor != 2'd3) : (floor != 2'd0);
    assign stops      = bus.StopsUp | bus.StopsDw;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign door_hold = bus.DoorHold;
`else
    assign door_hold = 1'b0;
`endif

    // Any pending stop strictly ahead of the cabin in the latched direction.
    always_comb begin
        stop_beyond = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ud && (i > int'(floor))) begin
                stop_beyond = stop_beyond | stops[i];
            end
            if (!ud && (i < int'(floor))) begin
                stop_beyond = stop_beyond | stops[i];
            end
        end
    end

    // State, position, direction and counter update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            oc_q  <= 1'b0;
            floor <= 2'd0;
            ud    <= 1'b1;
        end else begin
            oc_q <= bus.OCRequest;
            case (state)
                IDLE: begin
                    if (oc_rise) begin
                        state <= DOOR;
                        cnt   <= '0;
                    end else if (bus.NoStopRequest && move_legal) begin
                        state <= MOVE;
                        ud    <= bus.UDRequest;
                        cnt   <= '0;
                    end
                end
                MOVE: begin
                    if (cnt == TRAVEL_LAST) begin
                        floor <= ud ? (floor + 2'd1) : (floor - 2'd1);
                        cnt   <= '0;
                        state <= ARRIVE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ARRIVE: begin
                    // The Delay strobe is up this cycle, so the memory manager
                    // can answer with OCRequest before EVAL samples it.
                    state <= EVAL;
                end
                EVAL: begin
                    cnt <= '0;
                    if (bus.OCRequest) begin
                        state <= DOOR;
                    end else if (stop_beyond) begin
                        state <= MOVE;
                    end else begin
                        state <= IDLE;
                    end
                end
                DOOR: begin
                    if (door_hold) begin
                        cnt <= '0;
                    end else if (cnt == DOOR_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Status outputs decode only from registers, so no input reaches an output
    // combinationally.
    assign bus.CurrentFloor = floor;
    assign bus.UDIn         = ud;
    assign bus.Delay        = (state == ARRIVE);
    assign bus.Stop         = (state == IDLE);
    assign bus.Moving       = (state == MOVE);
    assign bus.DoorOpen     = (state == DOOR);
    assign bus.fsm_state    = state;

endmodule

// File: tb/tb_elevator_motion_controller.sv
// Directed bench for elevator_motion_controller with TRAVEL_TICKS=4 and DOOR_TICKS=3.
// Define ELEVATOR_DOOR_HOLD_EN to also exercise the DoorHold path.
module tb_elevator_motion_controller;

    localparam int TT = 4;
    localparam int DT = 3;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    elevator_motion_controller_if bus ();

    elevator_motion_controller #(
        .TRAVEL_TICKS(TT),
        .DOOR_TICKS  (DT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Packed status: {0, CurrentFloor[1:0], UDIn, Delay, Stop, Moving, DoorOpen}
    logic [7:0] obs;
    assign obs = {1'b0, bus.CurrentFloor, bus.UDIn, bus.Delay, bus.Stop, bus.Moving, bus.DoorOpen};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] s_idle(input logic [1:0] f, input logic u);
        return {1'b0, f, u, 1'b0, 1'b1, 1'b0, 1'b0};
    endfunction
    function automatic logic [7:0] s_move(input logic [1:0] f, input logic u);
        return {1'b0, f, u, 1'b0, 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic logic [7:0] s_arr(input logic [1:0] f, input logic u);
        return {1'b0, f, u, 1'b1, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [7:0] s_eval(input logic [1:0] f, input logic u);
        return {1'b0, f, u, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [7:0] s_door(input logic [1:0] f, input logic u);
        return {1'b0, f, u, 1'b0, 1'b0, 1'b0, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got flr/ud/dly/stp/mov/dor=%b expected %b", tag, got[6:0], want[6:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.NoStopRequest = 1'b0;
        bus.UDRequest     = 1'b0;
        bus.OCRequest     = 1'b0;
        bus.StopsUp       = 4'b0000;
        bus.StopsDw       = 4'b0000;
`ifdef ELEVATOR_DOOR_HOLD_EN
        bus.DoorHold      = 1'b0;
`endif

        // Reset values appear without a clock edge.
        #2 reset = 1'b0;
        #1 check("reset_init", obs, s_idle(2'd0, 1'b1));
        tick();
        tick();
        check("reset_hold", obs, s_idle(2'd0, 1'b1));
        reset = 1'b1;

        // Up one floor with no pending stops: the cabin parks at floor 1.
        bus.UDRequest     = 1'b1;
        bus.NoStopRequest = 1'b1;
        for (int k = 0; k < TT; k++) begin
            tick();
            check("b_move", obs, s_move(2'd0, 1'b1));
            bus.NoStopRequest = 1'b0;
        end
        tick();
        check("b_arrive", obs, s_arr(2'd1, 1'b1));
        tick();
        check("b_eval", obs, s_eval(2'd1, 1'b1));
        tick();
        check("b_idle", obs, s_idle(2'd1, 1'b1));
        tick();
        tick();
        check("b_parked", obs, s_idle(2'd1, 1'b1));

        // Reset during a downward move from floor 1 loses position and direction.
        bus.UDRequest     = 1'b0;
        bus.NoStopRequest = 1'b1;
        tick();
        check("c_move_dn", obs, s_move(2'd1, 1'b0));
        bus.NoStopRequest = 1'b0;
        tick();
        check("c_move_dn2", obs, s_move(2'd1, 1'b0));
        #2 reset = 1'b0;
        #1 check("c_reset_async", obs, s_idle(2'd0, 1'b1));
        tick();
        check("c_reset_held", obs, s_idle(2'd0, 1'b1));
        reset = 1'b1;
        tick();
        tick();
        check("c_released", obs, s_idle(2'd0, 1'b1));

        // Run 0 -> 3 with a pending up-stop at floor 3, door opened on arrival.
        bus.StopsUp       = 4'b1000;
        bus.UDRequest     = 1'b1;
        bus.NoStopRequest = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            for (int k = 0; k < TT; k++) begin
                tick();
                check("d_move", obs, s_move(2'(f - 1), 1'b1));
            end
            tick();
            check("d_arrive", obs, s_arr(2'(f), 1'b1));
            if (f == 3) bus.OCRequest = 1'b1;
            tick();
            check("d_eval", obs, s_eval(2'(f), 1'b1));
        end
        for (int k = 0; k < DT; k++) begin
            tick();
            check("d_door", obs, s_door(2'd3, 1'b1));
        end
        tick();
        check("d_parked", obs, s_idle(2'd3, 1'b1));

        // Up request at the top floor is refused; held OCRequest does not reopen.
        for (int k = 0; k < 20; k++) begin
            tick();
            check("e_illegal", obs, s_idle(2'd3, 1'b1));
        end
        bus.StopsUp       = 4'b0000;
        bus.NoStopRequest = 1'b0;

        // A fresh OCRequest edge opens the door one cycle later.
        bus.OCRequest = 1'b0;
        tick();
        check("f_oc_low", obs, s_idle(2'd3, 1'b1));
        bus.OCRequest = 1'b1;
        tick();
        check("f_oc_rise", obs, s_door(2'd3, 1'b1));
        for (int k = 0; k < DT - 1; k++) begin
            tick();
            check("f_door", obs, s_door(2'd3, 1'b1));
        end
        tick();
        check("f_door_done", obs, s_idle(2'd3, 1'b1));
        tick();
        tick();
        check("f_no_reopen", obs, s_idle(2'd3, 1'b1));

        // Down from floor 3 with no stops: parks at floor 2.
        bus.OCRequest     = 1'b0;
        bus.UDRequest     = 1'b0;
        bus.NoStopRequest = 1'b1;
        tick();
        check("g_move", obs, s_move(2'd3, 1'b0));
        bus.NoStopRequest = 1'b0;
        for (int k = 0; k < TT - 1; k++) begin
            tick();
            check("g_move", obs, s_move(2'd3, 1'b0));
        end
        tick();
        check("g_arrive", obs, s_arr(2'd2, 1'b0));
        tick();
        check("g_eval", obs, s_eval(2'd2, 1'b0));
        tick();
        check("g_idle", obs, s_idle(2'd2, 1'b0));

        // Door edge and run request together: door first, then the run.
        bus.OCRequest     = 1'b1;
        bus.NoStopRequest = 1'b1;
        bus.UDRequest     = 1'b1;
        tick();
        check("h_door_wins", obs, s_door(2'd2, 1'b0));
        for (int k = 0; k < DT - 1; k++) begin
            tick();
            check("h_door", obs, s_door(2'd2, 1'b0));
        end
        tick();
        check("h_idle", obs, s_idle(2'd2, 1'b0));
        tick();
        check("h_run", obs, s_move(2'd2, 1'b1));
        bus.NoStopRequest = 1'b0;
        bus.OCRequest     = 1'b0;
        for (int k = 0; k < TT - 1; k++) begin
            tick();
            check("h_move", obs, s_move(2'd2, 1'b1));
        end
        tick();
        check("h_arrive", obs, s_arr(2'd3, 1'b1));
        tick();
        check("h_eval", obs, s_eval(2'd3, 1'b1));
        tick();
        check("h_top_idle", obs, s_idle(2'd3, 1'b1));

`ifdef ELEVATOR_DOOR_HOLD_EN
        // DoorHold freezes the dwell; DT cycles of door remain once it drops.
        bus.DoorHold  = 1'b1;
        bus.OCRequest = 1'b1;
        tick();
        check("i_door", obs, s_door(2'd3, 1'b1));
        for (int k = 0; k < 10; k++) begin
            tick();
            check("i_hold", obs, s_door(2'd3, 1'b1));
        end
        bus.DoorHold  = 1'b0;
        bus.OCRequest = 1'b0;
        for (int k = 0; k < DT - 1; k++) begin
            tick();
            check("i_tail", obs, s_door(2'd3, 1'b1));
        end
        tick();
        check("i_idle", obs, s_idle(2'd3, 1'b1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
